serializador_datos: RTL and testbench



---
 rtl/serializador_datos.sv | 159 +++++++++++++++
 tb/tb_serializador_datos.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serializador_datos.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : serializador_datos                                            |
// | Purpose  : Self-sequencing parallel-to-serial transmitter. Latches a     |
// |            word on an accepted load, then drives serial data, a divided  |
// |            bit clock and an active-low frame select, MSB- or LSB-first.  |
// | Option   : define SERIALIZADOR_PARIDAD_EN to append an even-parity bit   |
// |            after the last data bit (frame grows to ANCHO+1 bits).        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module serializador_datos #(
  parameter int ANCHO = 16,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ANCHO-1:0] datos,
  input  logic             cargar,
  input  logic             msb_primero,
  output logic             salida,
  output logic             sclk,
  output logic             cs_n,
  output logic             listo,
  output logic             fin
);

`ifdef SERIALIZADOR_PARIDAD_EN
  localparam int NBITS = ANCHO + 1;
`else
  localparam int NBITS = ANCHO;
`endif
  localparam int IW = $clog2(NBITS + 1);
  localparam int CW = $clog2(DIV);

  localparam logic [IW-1:0] IDX_ULTIMO = IW'(NBITS - 1);
  localparam logic [IW-1:0] IDX_MSB    = IW'(ANCHO - 1);
  localparam logic [CW-1:0] CNT_ULTIMO = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_MITAD  = CW'(DIV / 2);

  typedef enum logic [1:0] {
    REPOSO     = 2'd0,
    TRANSMITIR = 2'd1,
    FIN        = 2'd2
  } estado_t;

  estado_t          estado_q, estado_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ANCHO-1:0] palabra_q, palabra_d;
  logic             msb_q, msb_d;

  logic salida_q, salida_d;
  logic sclk_q, sclk_d;
  logic cs_n_q, cs_n_d;
  logic listo_q, listo_d;
  logic fin_q, fin_d;

  logic [IW-1:0]    pos;
  logic [ANCHO-1:0] desplazada;
  logic             bit_dato;

  // Sequencing: accept a load in REPOSO, step divider and bit index, close frame.
  always_comb begin
    estado_d  = estado_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    palabra_d = palabra_q;
    msb_d     = msb_q;
    case (estado_q)
      REPOSO: begin
        if (cargar) begin
          estado_d  = TRANSMITIR;
          idx_d     = '0;
          cnt_d     = '0;
          palabra_d = datos;
          msb_d     = msb_primero;
        end
      end
      TRANSMITIR: begin
        if (cnt_q == CNT_ULTIMO) begin
          cnt_d = '0;
          if (idx_q == IDX_ULTIMO) begin
            estado_d = FIN;
            idx_d    = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  // Output decode from the next-state values so every output is a flop.
  always_comb begin
    pos        = msb_d ? (IDX_MSB - idx_d) : idx_d;
    desplazada = palabra_d >> pos;
    bit_dato   = desplazada[0];
`ifdef SERIALIZADOR_PARIDAD_EN
    // Index ANCHO is the trailing parity slot, independent of bit order.
    if (idx_d == IW'(ANCHO)) begin
      bit_dato = ^palabra_d;
    end
`endif
    salida_d = 1'b0;
    sclk_d   = 1'b0;
    cs_n_d   = 1'b1;
    listo_d  = 1'b0;
    fin_d    = 1'b0;
    case (estado_d)
      REPOSO:  listo_d = 1'b1;
      TRANSMITIR: begin
        cs_n_d   = 1'b0;
        salida_d = bit_dato;
        sclk_d   = (cnt_d >= CNT_MITAD);
      end
      FIN:     fin_d = 1'b1;
      default: listo_d = 1'b0;
    endcase
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado_q  <= REPOSO;
      idx_q     <= '0;
      cnt_q     <= '0;
      palabra_q <= '0;
      msb_q     <= 1'b0;
      salida_q  <= 1'b0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      listo_q   <= 1'b1;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      palabra_q <= palabra_d;
      msb_q     <= msb_d;
      salida_q  <= salida_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      listo_q   <= listo_d;
      fin_q     <= fin_d;
    end
  end

  assign salida = salida_q;
  assign sclk   = sclk_q;
  assign cs_n   = cs_n_q;
  assign listo  = listo_q;
  assign fin    = fin_q;

endmodule
`default_nettype wire

// File: tb/tb_serializador_datos.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_serializador_datos                                         |
// | Purpose  : Self-checking bench for serializador_datos (ANCHO=16, DIV=4). |
// |            Honours SERIALIZADOR_PARIDAD_EN when defined.                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_serializador_datos;

  localparam int ANCHO = 16;
  localparam int DIV   = 4;
`ifdef SERIALIZADOR_PARIDAD_EN
  localparam int NB = ANCHO + 1;
`else
  localparam int NB = ANCHO;
`endif
  localparam int FRAME = NB * DIV;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cargar = 1'b0;
  logic             msb_primero = 1'b0;
  logic [ANCHO-1:0] datos = '0;
  logic             salida, sclk, cs_n, listo, fin;

  serializador_datos #(.ANCHO(ANCHO), .DIV(DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .datos      (datos),
    .cargar     (cargar),
    .msb_primero(msb_primero),
    .salida     (salida),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .listo      (listo),
    .fin        (fin)
  );

  always #5 clk = ~clk;

  // Cycle number: the value seen during a cycle is the spec's cycle index.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of expected serial bits, consumed at every sclk rising edge.
  bit sb[$];
  int low_cnt = 0;
  int fin_cnt = 0;
  int falls[$];
  int rises[$];
  logic sclk_prev = 1'b0;
  logic cs_prev   = 1'b1;

  always @(negedge clk) begin
    if (sclk === 1'b1 && sclk_prev === 1'b0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL bit_extra: unexpected sclk edge, salida=%0d (cycle %0d)", salida, cyc);
      end else begin
        chk("bit", salida, sb.pop_front());
      end
      if (falls.size() > 0)
        chk("sclk_phase", (cyc - falls[falls.size()-1]) % DIV, DIV / 2);
    end
    if (cs_n === 1'b0) low_cnt++;
    if (fin === 1'b1) fin_cnt++;
    if (cs_prev === 1'b1 && cs_n === 1'b0) falls.push_back(cyc);
    if (cs_prev === 1'b0 && cs_n === 1'b1) rises.push_back(cyc);
    sclk_prev = sclk;
    cs_prev   = cs_n;
  end

  typedef struct {
    logic [15:0] d;
    logic        msb;
    logic [15:0] seq;   // expected line order, first transmitted bit at [15]
    logic        par;
  } vec_t;

  vec_t vecs[6];

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(input vec_t v);
    for (int i = 0; i < 16; i++) sb.push_back(v.seq[15-i]);
`ifdef SERIALIZADOR_PARIDAD_EN
    sb.push_back(v.par);
`endif
  endtask

  task automatic run_frame(input vec_t v, input bit disturb);
    int t0;
    bit got;
    low_cnt = 0;
    fin_cnt = 0;
    push_exp(v);
    datos       = v.d;
    msb_primero = v.msb;
    cargar      = 1'b1;
    t0          = cyc;
    tick;
    cargar = 1'b0;
    chk("start_cs_n", cs_n, 0);
    chk("start_listo", listo, 0);
    got = 1'b0;
    for (int k = 0; k < FRAME + 20 && !got; k++) begin
      if (disturb && cyc == t0 + 10) begin
        cargar      = 1'b1;
        datos       = 16'hFFFF;
        msb_primero = ~v.msb;
      end else begin
        cargar = 1'b0;
      end
      if (fin === 1'b1) begin
        got = 1'b1;
        chk("fin_cycle", cyc - t0, FRAME + 1);
      end else begin
        tick;
      end
    end
    cargar = 1'b0;
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL fin_timeout: no fin within %0d cycles", FRAME + 20);
    end
    tick;
    chk("listo_back", listo, 1);
    chk("listo_cycle", cyc - t0, FRAME + 2);
    chk("cs_low_cycles", low_cnt, FRAME);
    chk("fin_pulses", fin_cnt, 1);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int t0;
    vecs[0] = '{16'hA53C, 1'b1, 16'hA53C, 1'b0};
    vecs[1] = '{16'hA53C, 1'b0, 16'h3CA5, 1'b0};
    vecs[2] = '{16'h0001, 1'b1, 16'h0001, 1'b1};
    vecs[3] = '{16'h1234, 1'b0, 16'h2C48, 1'b1};
    vecs[4] = '{16'h8000, 1'b0, 16'h0001, 1'b1};
    vecs[5] = '{16'hFFFF, 1'b1, 16'hFFFF, 1'b0};

    reset_n = 1'b0;
    tick;
    tick;
    chk("rst_salida", salida, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_listo", listo, 1);
    chk("rst_fin", fin, 0);
    reset_n = 1'b1;
    tick;

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], 1'b0);
      tick;
    end

    // Load request and data change mid-frame must not disturb the frame.
    run_frame(vecs[0], 1'b1);
    tick;

    // Reset pulse mid-frame aborts it with no fin.
    fin_cnt = 0;
    push_exp(vecs[0]);
    datos       = vecs[0].d;
    msb_primero = vecs[0].msb;
    cargar      = 1'b1;
    t0          = cyc;
    tick;
    cargar = 1'b0;
    for (int k = 0; k < 40 && cyc < t0 + 20; k++) tick;
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    chk("abort_cs_n", cs_n, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_salida", salida, 0);
    chk("abort_listo", listo, 1);
    chk("abort_fin", fin, 0);
    sb.delete();
    repeat (FRAME + 10) tick;
    chk("abort_no_fin", fin_cnt, 0);
    run_frame(vecs[1], 1'b0);
    tick;

    // Load held high: back-to-back frames, FIN plus one idle cycle between.
    falls.delete();
    rises.delete();
    fin_cnt = 0;
    repeat (3) push_exp(vecs[2]);
    datos       = vecs[2].d;
    msb_primero = vecs[2].msb;
    cargar      = 1'b1;
    t0          = cyc;
    for (int k = 0; k < 4 * FRAME && fin_cnt < 3; k++) tick;
    cargar = 1'b0;
    chk("cont_fin_count", fin_cnt, 3);
    tick;
    tick;
    tick;
    chk("cont_frames", falls.size(), 3);
    if (falls.size() >= 3 && rises.size() >= 1) begin
      chk("cont_start0", falls[0] - t0, 1);
      chk("cont_spacing1", falls[1] - falls[0], FRAME + 2);
      chk("cont_spacing2", falls[2] - falls[1], FRAME + 2);
      chk("cont_cs_gap", falls[1] - rises[0], 2);
    end
    chk("cont_sb_empty", sb.size(), 0);
    chk("cont_idle_listo", listo, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
